// File: rtl/display_page_ctrl_if.sv
// Bundles the result, entry-digit, paging and seg7 digit signals of display_page_ctrl.
// master drives the result and button side; slave is the controller itself.
interface display_page_ctrl_if;
   logic        result_valid;
   logic [31:0] result_in;
   logic        select;
   logic        advance_btn;
   logic [3:0]  data_in_ones;
   logic [3:0]  data_in_tens;
   logic [3:0]  data_in_hundreds;
   logic [3:0]  data_in_thousands;
   logic [3:0]  ones;
   logic [3:0]  tens;
   logic [3:0]  hundreds;
   logic [3:0]  thousands;
   logic [1:0]  LEDs_out;
   logic        busy;
   logic        bcd_ready;

   modport master (
      output result_valid, result_in, select, advance_btn,
             data_in_ones, data_in_tens, data_in_hundreds, data_in_thousands,
      input  ones, tens, hundreds, thousands, LEDs_out, busy, bcd_ready
   );

   modport slave (
      input  result_valid, result_in, select, advance_btn,
             data_in_ones, data_in_tens, data_in_hundreds, data_in_thousands,
      output ones, tens, hundreds, thousands, LEDs_out, busy, bcd_ready
   );
endinterface

// File: rtl/display_page_ctrl.sv
// Converts a 32-bit result to 10 BCD digits (one double-dabble step per cycle) and pages
// them to seg7 four digits at a time. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module display_page_ctrl (
   input  logic               CLK100MHz,
   input  logic               reset,
   display_page_ctrl_if.slave bus
);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t      state, state_next;
   logic [31:0] shift_reg;
   logic [39:0] bcd_acc;
   logic [4:0]  iter_cnt;
   logic [39:0] display_reg;
   logic [1:0]  page;
   logic [1:0]  page_count;
   logic [1:0]  page_count_next;
   logic        pend_valid;
   logic [31:0] pend_value;
   logic        adv_q;
   logic        adv_edge;
   logic        busy_q;
   logic        bcd_ready_q;
   logic        launch;
   logic [31:0] launch_value;
   logic        last_iter;
   logic [39:0] bcd_adj;
   logic [39:0] bcd_next;
   logic [31:0] shift_next;
   logic [63:0] display_pad;
   logic [15:0] window;
   logic [15:0] digits_next;
   logic [1:0]  leds_next;
   logic [15:0] digits_q;
   logic [1:0]  leds_q;

   assign bus.busy      = busy_q;
   assign bus.bcd_ready = bcd_ready_q;
   assign bus.ones      = digits_q[3:0];
   assign bus.tens      = digits_q[7:4];
   assign bus.hundreds  = digits_q[11:8];
   assign bus.thousands = digits_q[15:12];
   assign bus.LEDs_out  = leds_q;

   // One double-dabble iteration: correct every nibble >= 5, then shift the pair left.
   always_comb begin
      bcd_adj = bcd_acc;
      for (int i = 0; i < 10; i++) begin
         if (bcd_acc[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
         end
      end
      {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
   end

   always_comb begin
      if (bcd_next[39:16] == 24'd0) begin
         page_count_next = 2'd1;
      end else if (bcd_next[39:32] == 8'd0) begin
         page_count_next = 2'd2;
      end else begin
         page_count_next = 2'd3;
      end
   end

   always_ff @(posedge CLK100MHz) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A fresh result_valid in IDLE takes priority over the held pending value.
   always_comb begin
      state_next   = state;
      launch       = 1'b0;
      launch_value = pend_value;
      last_iter    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.result_valid) begin
               launch       = 1'b1;
               launch_value = bus.result_in;
               state_next   = CONVERT;
            end else if (pend_valid) begin
               launch     = 1'b1;
               state_next = CONVERT;
            end
         end
         CONVERT: begin
            if (iter_cnt == 5'd31) begin
               last_iter  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHz) begin
      if (reset) begin
         shift_reg   <= '0;
         bcd_acc     <= '0;
         iter_cnt    <= '0;
         pend_valid  <= 1'b0;
         pend_value  <= '0;
         display_reg <= '0;
         bcd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         busy_q <= (state == CONVERT);
         if (launch) begin
            shift_reg <= launch_value;
            bcd_acc   <= '0;
            iter_cnt  <= '0;
         end else if (state == CONVERT) begin
            shift_reg <= shift_next;
            bcd_acc   <= bcd_next;
            iter_cnt  <= iter_cnt + 5'd1;
         end
         if ((state == CONVERT) && bus.result_valid) begin
            pend_valid <= 1'b1;
            pend_value <= bus.result_in;
         end else if (launch) begin
            pend_valid <= 1'b0;
         end
         if (last_iter) begin
            display_reg <= bcd_next;
            bcd_ready_q <= 1'b1;
         end
      end
   end

   // The edge is registered once more so a press updates page one cycle after it is seen.
   always_ff @(posedge CLK100MHz) begin
      if (reset) begin
         adv_q      <= 1'b0;
         adv_edge   <= 1'b0;
         page       <= 2'd0;
         page_count <= 2'd1;
      end else begin
         adv_q    <= bus.advance_btn;
         adv_edge <= bus.advance_btn & ~adv_q;
         if (last_iter) begin
            page       <= 2'd0;
            page_count <= page_count_next;
         end else if (adv_edge && bus.select && bcd_ready_q) begin
            page <= (page == page_count - 2'd1) ? 2'd0 : page + 2'd1;
         end
      end
   end

   assign display_pad = {24'd0, display_reg};
   assign window      = display_pad[{page, 4'b0000} +: 16];

`ifdef LEADING_ZERO_BLANK_EN
   logic [3:0] msd;

   always_comb begin
      msd = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (display_reg[i*4 +: 4] != 4'd0) begin
            msd = 4'(i);
         end
      end
   end
`endif

   always_comb begin
      digits_next = 16'd0;
      leds_next   = 2'b00;
      if (!bus.select) begin
         digits_next = {bus.data_in_thousands, bus.data_in_hundreds,
                        bus.data_in_tens, bus.data_in_ones};
      end else if (bcd_ready_q) begin
         digits_next = window;
         leds_next   = page;
`ifdef LEADING_ZERO_BLANK_EN
         for (int d = 0; d < 4; d++) begin
            if ({page, 2'(d)} > msd) begin
               digits_next[d*4 +: 4] = 4'hF;
            end
         end
`endif
      end
   end

   always_ff @(posedge CLK100MHz) begin
      if (reset) begin
         digits_q <= '0;
         leds_q   <= 2'b00;
      end else begin
         digits_q <= digits_next;
         leds_q   <= leds_next;
      end
   end

endmodule
